pipeline_stage_skid: RTL and testbench

//   Generic, parametrised inter-stage pipeline register for the pipelined datapath.

---
 rtl/pipeline_stage_skid.sv | 141 ++++++++++++++
 tb/tb_pipeline_stage_skid.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
//   Inter-stage pipeline register with a valid/ready handshake. It carries a
//   datapath payload and a control bundle from one pipeline stage to the next.
//   Back-pressure propagates upstream through in_ready. A flush squashes every
//   held entry and any entry offered in the same cycle. While the stage is
//   empty, out_ctrl reads all-zero, so the downstream stage sees a NOP bubble.
//
//   SKID=1 : 2-entry skid buffer. in_ready is decoded from registered state only,
//            so the stall path from out_ready to in_ready is broken.
//   SKID=0 : single register. in_ready = !out_valid | out_ready (combinational).
//
// Ports
//   CLK        clock, rising edge
//   nRST       synchronous active-low reset
//   flush      squash held entries and the entry offered this cycle
//   in_valid   upstream offers in_data/in_ctrl
//   in_ready   stage accepts this cycle
//   in_data    payload from upstream          [DATA_W]
//   in_ctrl    control bundle from upstream   [CTRL_W]
//   out_valid  out_data/out_ctrl hold a valid entry
//   out_ready  downstream accepts
//   out_data   payload to downstream; holds its last value while empty
//   out_ctrl   control to downstream; zero while out_valid=0
//   occ        number of entries held (0..2)
module pipeline_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_p0;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_data_p0;
  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [DATA_W-1:0] skid_data_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;

  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  always_comb begin
    if (SKID != 0) in_ready = (state_p0 != TWO);
    else           in_ready = (state_p0 == EMPTY) || out_ready;
  end

  assign out_valid = (state_p0 != EMPTY);
  // An entry offered in a flush cycle is dropped even when in_ready reads 1.
  assign in_xfer   = in_valid && in_ready && !flush;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with the skid register present: without it,
            // in_ready is low whenever the held entry cannot leave.
            if (SKID != 0) begin
              load_skid = 1'b1;
              state_nxt = TWO;
            end
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---- stage boundary: state and entry registers ----
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_p0     <= EMPTY;
      main_data_p0 <= '0;
      main_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (load_main_in) begin
        main_data_p0 <= in_data;
        main_ctrl_p0 <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_p0 <= skid_data_p0;
        main_ctrl_p0 <= skid_ctrl_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= in_data;
        skid_ctrl_p0 <= in_ctrl;
      end
    end
  end

  assign out_data = main_data_p0;
  assign out_ctrl = out_valid ? main_ctrl_p0 : '0;
  assign occ      = (state_p0 == TWO) ? 2'd2 : ((state_p0 == ONE) ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_pipeline_stage_skid.sv
module tb_pipeline_stage_skid;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [15:0] out_ctrl1;
  logic [1:0]  occ1;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [15:0] out_ctrl0;
  logic [1:0]  occ0;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
  } item_t;

  item_t q1[$];
  item_t q0[$];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(1)) dut1 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occ(occ1)
  );

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occ(occ0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected entry whenever a downstream transfer is about
  // to happen at the next rising edge, and checks occupancy and bubble rule.
  always @(negedge CLK) begin
    if (nRST !== 1'b1) begin
      q1.delete();
      q0.delete();
    end else begin
      chk("occ_skid1", 64'(occ1), 64'(q1.size()));
      if (!out_valid1) chk("bubble_ctrl_skid1", 64'(out_ctrl1), 64'h0);
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_out_skid1", 64'(out_data1), 64'hDEAD_DEAD);
        end else begin
          item_t e;
          e = q1.pop_front();
          chk("data_skid1", 64'(out_data1), 64'(e.d));
          chk("ctrl_skid1", 64'(out_ctrl1), 64'(e.c));
        end
      end
      if (flush) q1.delete();

      chk("occ_skid0", 64'(occ0), 64'(q0.size()));
      if (!out_valid0) chk("bubble_ctrl_skid0", 64'(out_ctrl0), 64'h0);
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          chk("unexpected_out_skid0", 64'(out_data0), 64'hDEAD_DEAD);
        end else begin
          item_t e;
          e = q0.pop_front();
          chk("data_skid0", 64'(out_data0), 64'(e.d));
          chk("ctrl_skid0", 64'(out_ctrl0), 64'(e.c));
        end
      end
      if (flush) q0.delete();
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: record accepted entries, then return just after the next edge.
  task automatic tick();
    item_t e;
    @(negedge CLK);
    #1;
    if (nRST === 1'b1 && in_valid && !flush) begin
      e.d = in_data;
      e.c = in_ctrl;
      if (in_ready1) q1.push_back(e);
      if (in_ready0) q0.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    drive(v, d, 16'h00A5, ordy, fl);
    tick();
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b1, 32'h0000_0099, 16'h00A5, 1'b1, 1'b0);

    // Reset with in_valid held high
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 64'(out_valid1), 64'h0);
    chk("rst_out_ctrl",  64'(out_ctrl1),  64'h0);
    chk("rst_out_data",  64'(out_data1),  64'h0);
    chk("rst_occ",       64'(occ1),       64'h0);
    chk("rst_in_ready",  64'(in_ready1),  64'h1);
    chk("rst_out_valid0", 64'(out_valid0), 64'h0);
    chk("rst_in_ready0",  64'(in_ready0),  64'h1);
    nRST = 1'b1;

    // Streaming 1..8, one cycle latency, no bubbles
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_valid1", 64'(out_valid1), 64'h1);
      chk("stream_data1",  64'(out_data1),  64'(i));
      chk("stream_ctrl1",  64'(out_ctrl1),  64'h00A5);
      chk("stream_data0",  64'(out_data0),  64'(i));
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_valid",   64'(out_valid1), 64'h0);
    chk("drain_ctrl",    64'(out_ctrl1),  64'h0);
    chk("drain_hold",    64'(out_data1),  64'h8);

    // Stall into the skid register
    cyc(1'b1, 32'h11, 1'b1, 1'b0);
    chk("skid_a_data", 64'(out_data1), 64'h11);
    cyc(1'b1, 32'h22, 1'b1, 1'b0);
    chk("skid_b_data", 64'(out_data1), 64'h22);
    cyc(1'b1, 32'h33, 1'b0, 1'b0);
    chk("skid_c_occ",      64'(occ1),      64'h2);
    chk("skid_c_in_ready", 64'(in_ready1), 64'h0);
    chk("skid_c_data",     64'(out_data1), 64'h22);
    cyc(1'b1, 32'h55, 1'b0, 1'b0);
    chk("skid_d_occ",  64'(occ1),      64'h2);
    chk("skid_d_data", 64'(out_data1), 64'h22);
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    chk("skid_e_data", 64'(out_data1), 64'h33);
    chk("skid_e_occ",  64'(occ1),      64'h1);
    cyc(1'b1, 32'h56, 1'b1, 1'b0);
    chk("skid_f_data", 64'(out_data1), 64'h56);
    cyc(1'b1, 32'h66, 1'b0, 1'b0);
    chk("skid_g_occ",  64'(occ1),      64'h2);

    // Flush while full, with a new entry offered
    cyc(1'b1, 32'h44, 1'b0, 1'b1);
    chk("flush_valid",    64'(out_valid1), 64'h0);
    chk("flush_ctrl",     64'(out_ctrl1),  64'h0);
    chk("flush_occ",      64'(occ1),       64'h0);
    chk("flush_in_ready", 64'(in_ready1),  64'h1);
    chk("flush_valid0",   64'(out_valid0), 64'h0);
    chk("flush_occ0",     64'(occ0),       64'h0);

    // Single-register pass-through
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    chk("pt_valid0", 64'(out_valid0), 64'h1);
    chk("pt_data0",  64'(out_data0),  64'h77);
    drive(1'b1, 32'h88, 16'h00A5, 1'b1, 1'b0);
    #1;
    chk("pt_in_ready_go0",    64'(in_ready0), 64'h1);
    out_ready = 1'b0;
    #1;
    chk("pt_in_ready_stall0", 64'(in_ready0), 64'h0);
    out_ready = 1'b1;
    #1;
    tick();
    chk("pt_valid0_b", 64'(out_valid0), 64'h1);
    chk("pt_data0_b",  64'(out_data0),  64'h88);
    chk("pt_data1_b",  64'(out_data1),  64'h88);

    // Random valid/ready/flush traffic
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 16'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      tick();
    end

    for (int n = 0; n < 4; n++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("final_empty_q1", 64'(q1.size()), 64'h0);
    chk("final_empty_q0", 64'(q0.size()), 64'h0);
    chk("final_valid1",   64'(out_valid1), 64'h0);
    chk("final_valid0",   64'(out_valid0), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
